// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: shared opcodes, default widths and instruction decode for the ID/EX stage.
package id_ex_stage_pkg;
  localparam int DW_DEF   = 32;
  localparam int AW_DEF   = 5;
  localparam int CNTW_DEF = 16;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [31:0] NOP     = 32'h0000_0000;
  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
  } instr_t;
  function automatic instr_t decode(input logic [31:0] i);
    decode = '{opcode: i[31:26], rs: i[25:21], rt: i[20:16], rd: i[15:11],
               shamt: i[10:6], funct: i[5:0], imm: i[15:0]};
  endfunction
endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: IF/ID, register file, forwarding and ID/EX signals of the decode stage.
interface id_ex_stage_if #(parameter int DW = 32, AW = 5, CNTW = 16);
  logic            id_valid;
  logic [DW-1:0]   id_instr;
  logic [DW-1:0]   id_pc;
  logic            flush;
  logic [AW-1:0]   regA;
  logic [AW-1:0]   regB;
  logic [DW-1:0]   Adat;
  logic [DW-1:0]   Bdat;
  logic            mem_wen;
  logic [AW-1:0]   mem_wreg;
  logic [DW-1:0]   mem_fwd_data;
  logic            wb_wen;
  logic [AW-1:0]   wb_wreg;
  logic [DW-1:0]   wb_data;
  logic            stall;
  logic            ex_valid;
  logic [DW-1:0]   ex_pc;
  logic [DW-1:0]   ex_a;
  logic [DW-1:0]   ex_b;
  logic [DW-1:0]   ex_imm;
  logic [5:0]      ex_opcode;
  logic [5:0]      ex_funct;
  logic [AW-1:0]   ex_rs;
  logic [AW-1:0]   ex_rt;
  logic [AW-1:0]   ex_rd;
  logic [4:0]      ex_shamt;
  logic [CNTW-1:0] stall_cnt;
  modport master (
    output id_valid, id_instr, id_pc, flush, Adat, Bdat,
           mem_wen, mem_wreg, mem_fwd_data, wb_wen, wb_wreg, wb_data,
    input  regA, regB, stall, ex_valid, ex_pc, ex_a, ex_b, ex_imm,
           ex_opcode, ex_funct, ex_rs, ex_rt, ex_rd, ex_shamt, stall_cnt
  );
  modport slave (
    input  id_valid, id_instr, id_pc, flush, Adat, Bdat,
           mem_wen, mem_wreg, mem_fwd_data, wb_wen, wb_wreg, wb_data,
    output regA, regB, stall, ex_valid, ex_pc, ex_a, ex_b, ex_imm,
           ex_opcode, ex_funct, ex_rs, ex_rt, ex_rd, ex_shamt, stall_cnt
  );
endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// fwd_mux: operand select with $zero guard, MEM over WB over register file.
module fwd_mux #(parameter int DW = 32, AW = 5) (
  input  logic [AW-1:0] r,
  input  logic [DW-1:0] d,
  input  logic          memWen,
  input  logic [AW-1:0] memWreg,
  input  logic [DW-1:0] memData,
  input  logic          wbWen,
  input  logic [AW-1:0] wbWreg,
  input  logic [DW-1:0] wbData,
  output logic [DW-1:0] q
);
  assign q = (r == '0) ? '0 :
             (memWen && memWreg == r) ? memData :
             (wbWen && wbWreg == r) ? wbData : d;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode/operand fetch with forwarding, load-use stall and the ID/EX register.
module id_ex_stage import id_ex_stage_pkg::*; #(
  parameter int DW = DW_DEF, AW = AW_DEF, CNTW = CNTW_DEF
) (
  input logic clk,
  input logic rst,
  id_ex_stage_if.slave bus
);
  instr_t d;
  logic [DW-1:0] fwdA, fwdB;
  logic loadHz;
  assign d = decode(bus.id_instr);
  assign bus.regA = d.rs;
  assign bus.regB = d.rt;
  // rt is compared even for non-R-type consumers; a spare bubble is cheaper than decoding uses
  assign loadHz = bus.ex_valid && bus.ex_opcode == OP_LW && bus.ex_rt != '0 && bus.id_valid &&
                  (bus.ex_rt == bus.regA || bus.ex_rt == bus.regB);
  assign bus.stall = loadHz && !bus.flush;
  fwd_mux #(.DW(DW), .AW(AW)) muxA (
    .r(bus.regA), .d(bus.Adat),
    .memWen(bus.mem_wen), .memWreg(bus.mem_wreg), .memData(bus.mem_fwd_data),
    .wbWen(bus.wb_wen), .wbWreg(bus.wb_wreg), .wbData(bus.wb_data),
    .q(fwdA)
  );
  fwd_mux #(.DW(DW), .AW(AW)) muxB (
    .r(bus.regB), .d(bus.Bdat),
    .memWen(bus.mem_wen), .memWreg(bus.mem_wreg), .memData(bus.mem_fwd_data),
    .wbWen(bus.wb_wen), .wbWreg(bus.wb_wreg), .wbData(bus.wb_data),
    .q(fwdB)
  );
  always_ff @(posedge clk) begin
    if (rst || bus.flush || loadHz) begin
      bus.ex_valid  <= 1'b0;
      bus.ex_pc     <= '0;
      bus.ex_a      <= '0;
      bus.ex_b      <= '0;
      bus.ex_imm    <= '0;
      bus.ex_opcode <= '0;
      bus.ex_funct  <= '0;
      bus.ex_rs     <= '0;
      bus.ex_rt     <= '0;
      bus.ex_rd     <= '0;
      bus.ex_shamt  <= '0;
    end else begin
      bus.ex_valid  <= bus.id_valid;
      bus.ex_pc     <= bus.id_pc;
      bus.ex_a      <= fwdA;
      bus.ex_b      <= fwdB;
      bus.ex_imm    <= {{(DW-16){d.imm[15]}}, d.imm};
      bus.ex_opcode <= d.opcode;
      bus.ex_funct  <= d.funct;
      bus.ex_rs     <= d.rs;
      bus.ex_rt     <= d.rt;
      bus.ex_rd     <= d.rd;
      bus.ex_shamt  <= d.shamt;
    end
    if (rst)
      bus.stall_cnt <= '0;
    else if (bus.stall && !(&bus.stall_cnt))
      bus.stall_cnt <= bus.stall_cnt + 1'b1;
  end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed and random checks of id_ex_stage against a program-order operand model.
module tb_id_ex_stage;
  localparam logic [31:0] LW15   = 32'h8C25_0000;
  localparam logic [31:0] ADD675 = 32'h00A7_3020;
  localparam logic [31:0] ADD322 = 32'h0042_1820;
  localparam logic [31:0] ADD300 = 32'h0000_1820;
  logic clk = 0;
  logic rst;
  int total = 0;
  int bad = 0;
  logic [31:0] rf [32];
  logic mKnown = 0;
  logic mValid;
  logic [31:0] mInstr, mPc, mA, mB;
  int mCnt;
  logic lastStall;
  logic [31:0] pcNext = 32'h0000_0004;
  id_ex_stage_if #(.DW(32), .AW(5), .CNTW(2)) bus ();
  id_ex_stage #(.DW(32), .AW(5), .CNTW(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // value a reader of r sees: newest in-flight writer wins over older ones and the regfile
  function automatic logic [31:0] fwdVal(input logic [4:0] r, input logic mw, input logic [4:0] mr,
      input logic [31:0] md, input logic ww, input logic [4:0] wr, input logic [31:0] wd);
    logic wen [2];
    logic [4:0] wreg [2];
    logic [31:0] wdat [2];
    logic [31:0] v;
    wen[0] = ww; wreg[0] = wr; wdat[0] = wd;
    wen[1] = mw; wreg[1] = mr; wdat[1] = md;
    v = rf[r];
    for (int i = 0; i < 2; i++) if (wen[i] && wreg[i] == r) v = wdat[i];
    return (r == 0) ? 32'h0 : v;
  endfunction

  task automatic issue(input logic v, input logic [31:0] instr, input logic fl,
      input logic mw, input logic [4:0] mr, input logic [31:0] md,
      input logic ww, input logic [4:0] wr, input logic [31:0] wd, input logic r);
    logic [4:0] ra, rb, prt;
    logic hz, st;
    @(negedge clk);
    rst = r;
    bus.id_valid = v; bus.id_instr = instr; bus.id_pc = pcNext; bus.flush = fl;
    bus.mem_wen = mw; bus.mem_wreg = mr; bus.mem_fwd_data = md;
    bus.wb_wen = ww; bus.wb_wreg = wr; bus.wb_data = wd;
    ra = instr[25:21];
    rb = instr[20:16];
    bus.Adat = rf[ra];
    bus.Bdat = rf[rb];
    #1;
    chk("regA", {27'b0, bus.regA}, {27'b0, ra});
    chk("regB", {27'b0, bus.regB}, {27'b0, rb});
    prt = mInstr[20:16];
    hz = mKnown && mValid && mInstr[31:26] == 6'h23 && prt != 0 && v && (prt == ra || prt == rb);
    st = hz && !fl;
    lastStall = bus.stall;
    if (mKnown) chk("stall", {31'b0, bus.stall}, {31'b0, st});
    if (r) begin
      mValid = 0; mInstr = 0; mPc = 0; mA = 0; mB = 0; mCnt = 0; mKnown = 1;
    end else begin
      if (st && mCnt < 3) mCnt++;
      if (fl || hz) begin
        mValid = 0; mInstr = 0; mPc = 0; mA = 0; mB = 0;
      end else begin
        mValid = v; mInstr = instr; mPc = pcNext;
        mA = fwdVal(ra, mw, mr, md, ww, wr, wd);
        mB = fwdVal(rb, mw, mr, md, ww, wr, wd);
      end
    end
    if (!st) pcNext += 4;
    @(posedge clk);
    #1;
    chk("ex_valid", {31'b0, bus.ex_valid}, {31'b0, mValid});
    chk("ex_pc", bus.ex_pc, mPc);
    chk("ex_a", bus.ex_a, mA);
    chk("ex_b", bus.ex_b, mB);
    chk("ex_imm", bus.ex_imm, 32'($signed(mInstr[15:0])));
    chk("ex_opcode", {26'b0, bus.ex_opcode}, {26'b0, mInstr[31:26]});
    chk("ex_funct", {26'b0, bus.ex_funct}, {26'b0, mInstr[5:0]});
    chk("ex_rs", {27'b0, bus.ex_rs}, {27'b0, mInstr[25:21]});
    chk("ex_rt", {27'b0, bus.ex_rt}, {27'b0, mInstr[20:16]});
    chk("ex_rd", {27'b0, bus.ex_rd}, {27'b0, mInstr[15:11]});
    chk("ex_shamt", {27'b0, bus.ex_shamt}, {27'b0, mInstr[10:6]});
    chk("stall_cnt", {30'b0, bus.stall_cnt}, mCnt[31:0]);
  endtask

  task automatic plain(input logic [31:0] instr, input logic fl, input logic r);
    issue(1, instr, fl, 0, 0, 0, 0, 0, 0, r);
  endtask

  initial begin
    logic [31:0] ins;
    logic [5:0] ops [4];
    ops[0] = 6'h00; ops[1] = 6'h08; ops[2] = 6'h23; ops[3] = 6'h2B;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[2] = 32'h33;
    mValid = 0; mInstr = 0; mPc = 0; mA = 0; mB = 0; mCnt = 0;
    plain(0, 0, 1);
    plain(0, 0, 1);
    chk("reset_cnt", {30'b0, bus.stall_cnt}, 32'h0);
    // forwarding priority
    issue(1, ADD322, 0, 1, 2, 32'h11, 1, 2, 32'h22, 0);
    chk("fwd_mem_a", bus.ex_a, 32'h11);
    chk("fwd_mem_b", bus.ex_b, 32'h11);
    issue(1, ADD322, 0, 0, 2, 32'h11, 1, 2, 32'h22, 0);
    chk("fwd_wb_a", bus.ex_a, 32'h22);
    issue(1, ADD300, 0, 1, 0, 32'hFFFF, 0, 0, 0, 0);
    chk("zero_guard", bus.ex_a, 32'h0);
    // sign extension
    plain(32'h2001_8001, 0, 0);
    chk("sext_neg", bus.ex_imm, 32'hFFFF_8001);
    plain(32'h2001_7FFF, 0, 0);
    chk("sext_pos", bus.ex_imm, 32'h0000_7FFF);
    // load-use bubble then forwarding from MEM
    plain(LW15, 0, 0);
    plain(ADD675, 0, 0);
    chk("lu_stall", {31'b0, lastStall}, 32'h1);
    chk("lu_bubble", {31'b0, bus.ex_valid}, 32'h0);
    chk("lu_cnt", {30'b0, bus.stall_cnt}, 32'h1);
    issue(1, ADD675, 0, 1, 5, 32'hABCD, 0, 0, 0, 0);
    chk("lu_fwd", bus.ex_a, 32'hABCD);
    chk("lu_valid", {31'b0, bus.ex_valid}, 32'h1);
    // flush beats hazard
    plain(LW15, 0, 0);
    plain(ADD675, 1, 0);
    chk("fl_stall", {31'b0, lastStall}, 32'h0);
    chk("fl_bubble", {31'b0, bus.ex_valid}, 32'h0);
    chk("fl_cnt", {30'b0, bus.stall_cnt}, 32'h1);
    // saturation of a 2-bit counter
    for (int k = 0; k < 4; k++) begin
      plain(LW15, 0, 0);
      plain(ADD675, 0, 0);
      plain(ADD675, 0, 0);
    end
    chk("sat_cnt", {30'b0, bus.stall_cnt}, 32'h3);
    // reset during a stall
    plain(LW15, 0, 0);
    plain(ADD675, 0, 1);
    chk("rst_stall_seen", {31'b0, lastStall}, 32'h1);
    chk("rst_valid", {31'b0, bus.ex_valid}, 32'h0);
    chk("rst_cnt", {30'b0, bus.stall_cnt}, 32'h0);
    chk("rst_opcode", {26'b0, bus.ex_opcode}, 32'h0);
    plain(ADD675, 0, 0);
    chk("rst_nostall", {31'b0, lastStall}, 32'h0);
    // random traffic
    for (int n = 0; n < 400; n++) begin
      ins = $urandom;
      ins[31:26] = ops[$urandom_range(0, 3)];
      ins[25:21] = 5'($urandom_range(0, 7));
      ins[20:16] = 5'($urandom_range(0, 7));
      issue($urandom_range(0, 9) != 0, ins, $urandom_range(0, 9) == 0,
            $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 49) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
